alu_2: RTL and testbench

64-bit combinational arithmetic/logic unit with a registered result/flag snapshot. The instruction-fetch stage uses its combinational result with ALUControl = 4'b0010 and rs2 = 4 to form PC+4 in the same cycle. The execute stage uses the full operation set. Integer-only; no multiply/divide.

---
 rtl/alu_2_pkg.sv | 26 ++
 rtl/alu_2_addsub.sv | 24 ++
 rtl/alu_2.sv | 88 ++++++++
 tb/tb_alu_2.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/alu_2_pkg.sv
// Shared constants for the 64-bit ALU: datapath width, opcode encodings
// and the bit positions of the registered flag snapshot.
package alu_2_pkg;

    localparam int XLEN = 64;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_SLL   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_SRA   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_NOR   = 4'b1010;
    localparam logic [3:0] ALU_PASSB = 4'b1011;

    // flags_q = {overflow, cout, negative, zero}
    localparam int FLAG_ZERO = 0;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_COUT = 2;
    localparam int FLAG_OVF  = 3;

endpackage

// File: rtl/alu_2_addsub.sv
// 65-bit adder/subtractor shared by ADD, SUB, SLT and SLTU.
// Subtraction is a + ~b + 1, so carry-out set means "no borrow".
import alu_2_pkg::*;

module alu_2_addsub (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            sub,
    output logic [XLEN-1:0] sum,
    output logic            cout,
    output logic            overflow
);

    logic [XLEN-1:0] b_eff;
    logic [XLEN:0]   wide_sum;

    assign b_eff    = sub ? ~b : b;
    assign wide_sum = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, sub};
    assign sum      = wide_sum[XLEN-1:0];
    assign cout     = wide_sum[XLEN];
    // Same-sign inputs to the adder producing a different-sign result.
    assign overflow = (a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);

endmodule

// File: rtl/alu_2.sv
// 64-bit combinational ALU with a registered snapshot of result and flags.
// The combinational path never depends on clk or reset.
import alu_2_pkg::*;

module alu_2 (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [XLEN-1:0]        rs1,
    input  logic [XLEN-1:0]        rs2,
    input  logic [3:0]             ALUControl,
    output logic signed [XLEN-1:0] rd,
    output logic                   zero,
    output logic                   cout,
    output logic                   overflow,
    output logic [XLEN-1:0]        rd_q,
    output logic [3:0]             flags_q
);

    logic            as_sub;
    logic [XLEN-1:0] as_sum;
    logic            as_cout;
    logic            as_ovf;
    logic [5:0]      shamt;
    logic            lt_signed;
    logic            lt_unsigned;

    // Compares need a subtraction too, so they share the adder.
    assign as_sub = (ALUControl == ALU_SUB) || (ALUControl == ALU_SLT) ||
                    (ALUControl == ALU_SLTU);
    assign shamt  = rs2[5:0];

    alu_2_addsub u_addsub (
        .a        (rs1),
        .b        (rs2),
        .sub      (as_sub),
        .sum      (as_sum),
        .cout     (as_cout),
        .overflow (as_ovf)
    );

    assign lt_signed   = as_sum[XLEN-1] ^ as_ovf;
    assign lt_unsigned = ~as_cout;

    always_comb begin
        rd       = '0;
        cout     = 1'b0;
        overflow = 1'b0;
        unique case (ALUControl)
            ALU_AND:   rd = rs1 & rs2;
            ALU_OR:    rd = rs1 | rs2;
            ALU_ADD: begin
                rd       = as_sum;
                cout     = as_cout;
                overflow = as_ovf;
            end
            ALU_XOR:   rd = rs1 ^ rs2;
            ALU_SLL:   rd = rs1 << shamt;
            ALU_SRL:   rd = rs1 >> shamt;
            ALU_SUB: begin
                rd       = as_sum;
                cout     = as_cout;
                overflow = as_ovf;
            end
            ALU_SLT:   rd = {{(XLEN-1){1'b0}}, lt_signed};
            ALU_SRA:   rd = $signed(rs1) >>> shamt;
            ALU_SLTU:  rd = {{(XLEN-1){1'b0}}, lt_unsigned};
            ALU_NOR:   rd = ~(rs1 | rs2);
            ALU_PASSB: rd = rs2;
            default:   rd = '0;
        endcase
    end

    assign zero = (rd == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q    <= '0;
            flags_q <= 4'b0000;
        end else begin
            rd_q               <= rd;
            flags_q[FLAG_OVF]  <= overflow;
            flags_q[FLAG_COUT] <= cout;
            flags_q[FLAG_NEG]  <= rd[XLEN-1];
            flags_q[FLAG_ZERO] <= zero;
        end
    end

endmodule

// File: tb/tb_alu_2.sv
// Directed testbench for alu_2: combinational operations, flags,
// snapshot register and asynchronous active-low reset.
module tb_alu_2;

    logic               clk;
    logic               reset;
    logic [63:0]        rs1;
    logic [63:0]        rs2;
    logic [3:0]         ALUControl;
    logic signed [63:0] rd;
    logic               zero;
    logic               cout;
    logic               overflow;
    logic [63:0]        rd_q;
    logic [3:0]         flags_q;

    int checks;
    int errors;

    alu_2 dut (
        .clk        (clk),
        .reset      (reset),
        .rs1        (rs1),
        .rs2        (rs2),
        .ALUControl (ALUControl),
        .rd         (rd),
        .zero       (zero),
        .cout       (cout),
        .overflow   (overflow),
        .rd_q       (rd_q),
        .flags_q    (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", tag, observed, expected);
        end
    endtask

    // Inputs change just after the falling edge, well clear of the capture edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [63:0] a,
                                 input logic [63:0] b);
        @(negedge clk);
        ALUControl = op;
        rs1        = a;
        rs2        = b;
        #1;
    endtask

    task automatic checkComb(input string tag, input logic [63:0] exp_rd,
                             input logic exp_zero, input logic exp_cout,
                             input logic exp_ovf);
        checkOutput({tag, "_rd"},   rd,               exp_rd);
        checkOutput({tag, "_zero"}, {63'd0, zero},     {63'd0, exp_zero});
        checkOutput({tag, "_cout"}, {63'd0, cout},     {63'd0, exp_cout});
        checkOutput({tag, "_ovf"},  {63'd0, overflow}, {63'd0, exp_ovf});
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        rs1        = '0;
        rs2        = '0;
        ALUControl = 4'b0000;

        #2;
        checkOutput("reset_rd_q",    rd_q,             64'd0);
        checkOutput("reset_flags_q", {60'd0, flags_q}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        applyStimulus(4'b0010, 64'd0, 64'd4);
        checkComb("pc4", 64'd4, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0010, 64'h1FC, 64'd4);
        checkComb("pc4_1fc", 64'h200, 1'b0, 1'b0, 1'b0);

        applyStimulus(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        checkComb("add_wrap", 64'd0, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        checkOutput("add_wrap_flags_q", {60'd0, flags_q}, 64'h5);

        applyStimulus(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        checkComb("add_ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        checkOutput("add_ovf_rd_q",    rd_q,             64'h8000_0000_0000_0000);
        checkOutput("add_ovf_flags_q", {60'd0, flags_q}, 64'hA);

        applyStimulus(4'b0110, 64'd5, 64'd7);
        checkComb("sub_neg", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0110, 64'd7, 64'd5);
        checkComb("sub_pos", 64'd2, 1'b0, 1'b1, 1'b0);
        applyStimulus(4'b0110, 64'h8000_0000_0000_0000, 64'd1);
        checkComb("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1);

        applyStimulus(4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        checkComb("slt", 64'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b1001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        checkComb("sltu", 64'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b0111, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
        checkComb("slt_ovf", 64'd0, 1'b1, 1'b0, 1'b0);

        applyStimulus(4'b1000, 64'h8000_0000_0000_0000, 64'h43);
        checkComb("sra", 64'hF000_0000_0000_0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0101, 64'h8000_0000_0000_0000, 64'h43);
        checkComb("srl", 64'h1000_0000_0000_0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0100, 64'd1, 64'hFFC0_0000_0000_003F);
        checkComb("sll63", 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0);

        applyStimulus(4'b0000, 64'hF0F0, 64'hFF00);
        checkComb("and", 64'hF000, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0001, 64'hF0F0, 64'hFF00);
        checkComb("or", 64'hFFF0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0011, 64'hF0F0, 64'hFF00);
        checkComb("xor", 64'h0FF0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b1010, 64'hF0F0, 64'hFF00);
        checkComb("nor", 64'hFFFF_FFFF_FFFF_000F, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b1011, 64'hDEAD, 64'h1234);
        checkComb("passb", 64'h1234, 1'b0, 1'b0, 1'b0);

        applyStimulus(4'b1111, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        checkComb("rsv1111", 64'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b1100, 64'h1234, 64'h5678);
        checkComb("rsv1100", 64'd0, 1'b1, 1'b0, 1'b0);

        applyStimulus(4'b0010, 64'd2, 64'd3);
        checkComb("add23", 64'd5, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        checkOutput("snap_rd_q",    rd_q,             64'd5);
        checkOutput("snap_flags_q", {60'd0, flags_q}, 64'd0);

        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("async_rst_rd_q",    rd_q,             64'd0);
        checkOutput("async_rst_flags_q", {60'd0, flags_q}, 64'd0);
        checkOutput("async_rst_rd",      rd,               64'd5);
        @(posedge clk); #1;
        checkOutput("held_rst_rd_q", rd_q, 64'd0);

        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("release_before_edge", rd_q, 64'd0);
        @(posedge clk); #1;
        checkOutput("release_rd_q", rd_q, 64'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
